// File: rtl/ground_pkg.sv
// Shared types and constants for the crumbling-ground tile sequencer.
package ground_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHAKE   = 3'd1,
    ST_CRACK   = 3'd2,
    ST_CRUMBLE = 3'd3,
    ST_GONE    = 3'd4
  } ground_state_t;

  localparam logic [1:0] FRAME_INTACT  = 2'd0;
  localparam logic [1:0] FRAME_CRACK   = 2'd1;
  localparam logic [1:0] FRAME_CRUMBLE = 2'd2;
  localparam logic [1:0] FRAME_GONE    = 2'd3;

  // Last step index of a state; a duration of 0 or 1 still lasts one tick.
  function automatic int last_step(input int ticks);
    return (ticks <= 1) ? 0 : ticks - 1;
  endfunction

  // Counter width for a modulus, never narrower than one bit.
  function automatic int cnt_width(input int modulus);
    return (modulus <= 2) ? 1 : $clog2(modulus);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ground_tile_fsm.sv
// One tile: state, shared step counter and registered frame/solid/pulse.
module ground_tile_fsm
  import ground_pkg::*;
#(
  parameter int SHAKE_TICKS   = 15,
  parameter int CRACK_TICKS   = 3,
  parameter int CRUMBLE_TICKS = 4,
  parameter int RESPAWN_TICKS = 40,
  parameter int STEP_W        = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tick,
  input  logic       i_touched,
  input  logic       i_respawn_en,
  output logic [1:0] o_frame,
  output logic       o_solid,
  output logic       o_collapse_pulse,
  output logic [2:0] o_dbg_state
);

  localparam logic [STEP_W-1:0] SHAKE_LAST   = STEP_W'(last_step(SHAKE_TICKS));
  localparam logic [STEP_W-1:0] CRACK_LAST   = STEP_W'(last_step(CRACK_TICKS));
  localparam logic [STEP_W-1:0] CRUMBLE_LAST = STEP_W'(last_step(CRUMBLE_TICKS));
  localparam logic [STEP_W-1:0] RESPAWN_LAST = STEP_W'(last_step(RESPAWN_TICKS));
  localparam logic [STEP_W-1:0] STEP_ONE     = STEP_W'(1);

  ground_state_t     r_state;
  logic [STEP_W-1:0] r_step;
  logic [1:0]        r_frame;
  logic              r_solid;
  logic              r_pulse;

  // Tile sequencer: outputs are registered alongside the state so they move
  // in the cycle after the tick that caused the transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_step  <= '0;
      r_frame <= FRAME_INTACT;
      r_solid <= 1'b1;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Entry tick is deliberately not counted.
          if (i_touched) begin
            r_state <= ST_SHAKE;
            r_step  <= '0;
          end
        end
        ST_SHAKE: begin
          // Untouched ticks pause the shake without losing progress.
          if (i_tick && i_touched) begin
            if (r_step == SHAKE_LAST) begin
              r_state <= ST_CRACK;
              r_step  <= '0;
              r_frame <= FRAME_CRACK;
            end else begin
              r_step <= r_step + STEP_ONE;
            end
          end
        end
        ST_CRACK: begin
          if (i_tick) begin
            if (r_step == CRACK_LAST) begin
              r_state <= ST_CRUMBLE;
              r_step  <= '0;
              r_frame <= FRAME_CRUMBLE;
              r_solid <= 1'b0;
            end else begin
              r_step <= r_step + STEP_ONE;
            end
          end
        end
        ST_CRUMBLE: begin
          if (i_tick) begin
            if (r_step == CRUMBLE_LAST) begin
              r_state <= ST_GONE;
              r_step  <= '0;
              r_frame <= FRAME_GONE;
              r_pulse <= 1'b1;
            end else begin
              r_step <= r_step + STEP_ONE;
            end
          end
        end
        ST_GONE: begin
          // Dropping respawn_en freezes the count where it is.
          if (i_tick && i_respawn_en) begin
            if (r_step == RESPAWN_LAST) begin
              r_state <= ST_IDLE;
              r_step  <= '0;
              r_frame <= FRAME_INTACT;
              r_solid <= 1'b1;
            end else begin
              r_step <= r_step + STEP_ONE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_step  <= '0;
          r_frame <= FRAME_INTACT;
          r_solid <= 1'b1;
        end
      endcase
    end
  end

  assign o_frame          = r_frame;
  assign o_solid          = r_solid;
  assign o_collapse_pulse = r_pulse;
  assign o_dbg_state      = r_state;

endmodule

// File: rtl/ground_crumble_ctrl.sv
// Shared animation tick divider plus one sequencer per ground tile.
module ground_crumble_ctrl
  import ground_pkg::*;
#(
  parameter int N_TILES       = 3,
  parameter int TICK_DIV      = 6000000,
  parameter int SHAKE_TICKS   = 15,
  parameter int CRACK_TICKS   = 3,
  parameter int CRUMBLE_TICKS = 4,
  parameter int RESPAWN_TICKS = 40
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_TILES-1:0]     touched,
  input  logic                   respawn_en,
  output logic                   tick,
  output logic [2*N_TILES-1:0]   frame_sel,
  output logic [N_TILES-1:0]     solid,
  output logic [N_TILES-1:0]     collapse_pulse,
  output logic [3*N_TILES-1:0]   dbg_state
);

  localparam int DIV_W  = cnt_width(TICK_DIV);
  localparam int STEP_W = cnt_width(max2(max2(SHAKE_TICKS, CRACK_TICKS),
                                         max2(CRUMBLE_TICKS, RESPAWN_TICKS)));
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(last_step(TICK_DIV));
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [DIV_W-1:0] r_div;
  logic             r_tick;

  // Free-running divider; the strobe is registered so it trails the count by one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_div  <= (r_div == DIV_LAST) ? '0 : r_div + DIV_ONE;
      r_tick <= (r_div == DIV_LAST);
    end
  end

  assign tick = r_tick;

  for (genvar g = 0; g < N_TILES; g++) begin : g_tile
    ground_tile_fsm #(
      .SHAKE_TICKS  (SHAKE_TICKS),
      .CRACK_TICKS  (CRACK_TICKS),
      .CRUMBLE_TICKS(CRUMBLE_TICKS),
      .RESPAWN_TICKS(RESPAWN_TICKS),
      .STEP_W       (STEP_W)
    ) u_tile (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_tick          (r_tick),
      .i_touched       (touched[g]),
      .i_respawn_en    (respawn_en),
      .o_frame         (frame_sel[2*g+1:2*g]),
      .o_solid         (solid[g]),
      .o_collapse_pulse(collapse_pulse[g]),
      .o_dbg_state     (dbg_state[3*g+2:3*g])
    );
  end

endmodule

// File: tb/tb_ground_crumble_ctrl.sv
// Bench for ground_crumble_ctrl: directed scenarios plus random touches,
// every cycle compared against a tick-budget model of the tiles.
module tb_ground_crumble_ctrl;

  localparam int NT = 3;
  localparam int TD = 4;
  localparam int ST = 3;
  localparam int CT = 2;
  localparam int CU = 2;
  localparam int RT = 5;

  localparam int P_IDLE    = 0;
  localparam int P_SHAKE   = 1;
  localparam int P_CRACK   = 2;
  localparam int P_CRUMBLE = 3;
  localparam int P_GONE    = 4;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst_n;
  logic [NT-1:0]   touched;
  logic            respawn_en;
  logic            tick;
  logic [2*NT-1:0] frame_sel;
  logic [NT-1:0]   solid;
  logic [NT-1:0]   collapse_pulse;
  logic [3*NT-1:0] dbg_state;

  always #5 clk = ~clk;

  ground_crumble_ctrl #(
    .N_TILES(NT), .TICK_DIV(TD), .SHAKE_TICKS(ST), .CRACK_TICKS(CT),
    .CRUMBLE_TICKS(CU), .RESPAWN_TICKS(RT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .touched(touched), .respawn_en(respawn_en),
    .tick(tick), .frame_sel(frame_sel), .solid(solid),
    .collapse_pulse(collapse_pulse), .dbg_state(dbg_state)
  );

  // ---------------- reference model ----------------
  int            tests = 0;
  int            fails = 0;
  int            m_phase[NT];
  int            m_rem[NT];
  int            m_cyc;
  logic [NT-1:0] m_pulse;
  int            tick_seen;
  int            pulse_cnt0;
  bit            seen_all_pulse;
  logic [12:0]   exp_q[$];

  function automatic int dur_of(input int p);
    int d;
    case (p)
      P_SHAKE:   d = ST;
      P_CRACK:   d = CT;
      P_CRUMBLE: d = CU;
      default:   d = RT;
    endcase
    return (d < 1) ? 1 : d;
  endfunction

  function automatic logic [12:0] model_out();
    logic [5:0] fr;
    logic [2:0] so;
    int fr_tab[5] = '{0, 0, 1, 2, 3};
    fr = '0;
    so = '0;
    for (int i = 0; i < NT; i++) begin
      fr[2*i +: 2] = 2'(fr_tab[m_phase[i]]);
      so[i]        = (m_phase[i] <= P_CRACK);
    end
    return {(m_cyc != 0) && (m_cyc % TD == 0), fr, so, m_pulse};
  endfunction

  task automatic model_reset();
    m_cyc   = 0;
    m_pulse = '0;
    for (int i = 0; i < NT; i++) begin
      m_phase[i] = P_IDLE;
      m_rem[i]   = 0;
    end
  endtask

  // Spend one tick of a tile's budget; move on when the budget is exhausted.
  task automatic spend(input int i);
    m_rem[i]--;
    if (m_rem[i] == 0) begin
      m_phase[i] = (m_phase[i] == P_GONE) ? P_IDLE : m_phase[i] + 1;
      m_rem[i]   = dur_of(m_phase[i]);
      if (m_phase[i] == P_GONE) m_pulse[i] = 1'b1;
    end
  endtask

  task automatic model_edge();
    bit t;
    t = (m_cyc != 0) && (m_cyc % TD == 0);
    m_pulse = '0;
    for (int i = 0; i < NT; i++) begin
      case (m_phase[i])
        P_IDLE:    if (touched[i]) begin m_phase[i] = P_SHAKE; m_rem[i] = dur_of(P_SHAKE); end
        P_SHAKE:   if (t && touched[i]) spend(i);
        P_GONE:    if (t && respawn_en) spend(i);
        default:   if (t) spend(i);
      endcase
    end
    m_cyc++;
    if (t) tick_seen++;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    logic [12:0] e;
    @(posedge clk);
    if (rst_n) model_edge();
    exp_q.push_back(model_out());
    #1;
    e = exp_q.pop_front();
    chk("tick",           32'(tick),           32'(e[12]));
    chk("frame_sel",      32'(frame_sel),      32'(e[11:6]));
    chk("solid",          32'(solid),          32'(e[5:3]));
    chk("collapse_pulse", 32'(collapse_pulse), 32'(e[2:0]));
    if (collapse_pulse[0]) pulse_cnt0++;
    if (collapse_pulse == 3'b111) seen_all_pulse = 1'b1;
  endtask

  task automatic run_ticks(input int n);
    int k = 0;
    tick_seen = 0;
    while (tick_seen < n && k < 500) begin
      cyc();
      k++;
    end
    chk("tick_budget", 32'(tick_seen >= n), 32'd1);
  endtask

  task automatic run_until_phase(input int tile, input int ph);
    int k = 0;
    while (m_phase[tile] != ph && k < 500) begin
      cyc();
      k++;
    end
    chk("phase_budget", 32'(m_phase[tile] == ph), 32'd1);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    touched    = '0;
    respawn_en = 1'b0;
    model_reset();
    repeat (2) cyc();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int k;
    int nticks;
    rst_n      = 1'b0;
    touched    = '0;
    respawn_en = 1'b0;
    pulse_cnt0 = 0;
    seen_all_pulse = 1'b0;
    model_reset();

    // 1: idle after reset, tick every 4th cycle starting at cycle 4
    do_reset();
    nticks = 0;
    k = 0;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      if (tick) begin
        nticks++;
        if (nticks == 1) k = c;
      end
    end
    chk("t1_tick_count", 32'(nticks), 32'd3);
    chk("t1_first_tick", 32'(k), 32'd4);

    // 2: tile 0 held touched through to GONE
    touched = 3'b001;
    pulse_cnt0 = 0;
    run_until_phase(0, P_GONE);
    repeat (6) cyc();
    chk("t2_pulse_count", 32'(pulse_cnt0), 32'd1);
    chk("t2_frame0", 32'(frame_sel[1:0]), 32'd3);
    chk("t2_others", 32'(frame_sel[5:2]), 32'd0);
    touched = 3'b000;

    // 3: tile 1 touched 2 ticks, gap 4 ticks, then one more -> CRACK
    run_ticks(1);
    touched = 3'b010;
    run_ticks(2);
    touched = 3'b000;
    run_ticks(4);
    chk("t3_gap_frame", 32'(frame_sel[3:2]), 32'd0);
    touched = 3'b010;
    run_ticks(1);
    chk("t3_crack", 32'(frame_sel[3:2]), 32'd1);

    // 5: respawn of tile 0 with a frozen stretch in the middle
    respawn_en = 1'b1;
    run_ticks(2);
    chk("t5_after2", 32'(frame_sel[1:0]), 32'd3);
    respawn_en = 1'b0;
    run_ticks(3);
    chk("t5_frozen", 32'(frame_sel[1:0]), 32'd3);
    respawn_en = 1'b1;
    run_ticks(2);
    chk("t5_after4", 32'(frame_sel[1:0]), 32'd3);
    run_ticks(1);
    chk("t5_restored_frame", 32'(frame_sel[1:0]), 32'd0);
    chk("t5_restored_solid", 32'(solid[0]), 32'd1);

    // 4: all three tiles touched together
    do_reset();
    seen_all_pulse = 1'b0;
    touched = 3'b111;
    k = 0;
    while (m_phase[2] != P_GONE && k < 500) begin
      cyc();
      chk("t4_same_frames", 32'({frame_sel[1:0], frame_sel[1:0]}), 32'(frame_sel[5:2]));
      k++;
    end
    repeat (2) cyc();
    chk("t4_all_pulse", 32'(seen_all_pulse), 32'd1);

    // 6: asynchronous reset while tile 0 is cracking
    do_reset();
    touched = 3'b001;
    run_until_phase(0, P_CRACK);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_tick", 32'(tick), 32'd0);
    chk("t6_frame", 32'(frame_sel), 32'd0);
    chk("t6_solid", 32'(solid), 32'd7);
    chk("t6_pulse", 32'(collapse_pulse), 32'd0);
    model_reset();
    touched = 3'b000;
    repeat (2) cyc();
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    do begin
      cyc();
      k++;
    end while (!tick && k < 20);
    chk("t6_first_tick", 32'(k), 32'd4);

    // random touches and respawn enables
    for (int c = 0; c < 600; c++) begin
      if (c % 8 == 0) touched = 3'($urandom_range(0, 7));
      if (c % 24 == 0) respawn_en = 1'($urandom_range(0, 1));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
